// File: rtl/platform_reset_pkg.sv
`default_nettype none
// Shared state encodings and default timing constants for the platform reset sequencer.
package platform_reset_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_REL_IC    = 3'd3,
    ST_RUN       = 3'd4,
    ST_SW_HOLD   = 3'd5
  } seq_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_STAGE_GAP       = 8;
  localparam int unsigned DEF_SW_HOLD_CYCLES  = 16;
  localparam logic [7:0]  RESTART_MAX         = 8'hFF;

  function automatic int unsigned max3_u(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pl_sync_2ff.sv
`default_nettype none
// Two-flop synchronizer with asynchronous active-low reset, for single-bit
// level signals crossing into the local clock domain.
module pl_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule
`default_nettype wire

// File: rtl/platform_reset_sequencer.sv
`default_nettype none
// Platform reset sequencer: debounces clock-wizard lock, then releases the
// interconnect and peripheral resets in order; restarts on lock loss or software request.
module platform_reset_sequencer
  import platform_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STAGE_GAP       = DEF_STAGE_GAP,
  parameter int unsigned SW_HOLD_CYCLES  = DEF_SW_HOLD_CYCLES
) (
  input  logic       pl_clk0,
  input  logic       pl_resetn,
  input  logic       clk_wiz_locked,
  input  logic       sw_reset_req,
  output logic       interconnect_aresetn,
  output logic       peripheral_aresetn,
  output logic       peripheral_reset,
  output logic       seq_done,
  output logic [2:0] seq_state,
  output logic [7:0] restart_count
);

  localparam int unsigned CNT_MAX = max3_u(DEBOUNCE_CYCLES, STAGE_GAP, SW_HOLD_CYCLES);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(SW_HOLD_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || STAGE_GAP < 1 || SW_HOLD_CYCLES < 1) begin : g_bad_param
    $error("platform_reset_sequencer: all stage lengths must be >= 1");
  end

  logic             locked_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       restart_q, restart_d;
  logic             ic_q, ic_d;
  logic             per_q, per_d;
  logic             prst_q;
  logic             done_q;
  logic             bump;

  pl_sync_2ff #(
    .RESET_VAL (1'b0)
  ) u_lock_sync (
    .clk_i  (pl_clk0),
    .rst_ni (pl_resetn),
    .d_i    (clk_wiz_locked),
    .q_o    (locked_s)
  );

  // The counter clears by default, so it restarts from zero on every state entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    restart_d = restart_q;
    bump      = 1'b0;

    unique case (state_q)
      ST_RESET: state_d = ST_WAIT_LOCK;
      ST_WAIT_LOCK: begin
        if (locked_s) state_d = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!locked_s)             state_d = ST_WAIT_LOCK;
        else if (cnt_q == DEB_LAST) state_d = ST_REL_IC;
        else                       cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_REL_IC: begin
        if (!locked_s)             state_d = ST_WAIT_LOCK;
        else if (cnt_q == GAP_LAST) state_d = ST_RUN;
        else                       cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          bump    = 1'b1;
        end else if (sw_reset_req) begin
          state_d = ST_SW_HOLD;
          bump    = 1'b1;
        end
      end
      ST_SW_HOLD: begin
        if (!locked_s || cnt_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_RESET;
    endcase

    if (bump && restart_q != RESTART_MAX) restart_d = restart_q + 8'd1;

    // Outputs decode the next state so they register on the same edge as the state.
    ic_d  = (state_d == ST_REL_IC) || (state_d == ST_RUN);
    per_d = (state_d == ST_RUN);
  end

  always_ff @(posedge pl_clk0 or negedge pl_resetn) begin
    if (!pl_resetn) begin
      state_q   <= ST_RESET;
      cnt_q     <= '0;
      restart_q <= '0;
      ic_q      <= 1'b0;
      per_q     <= 1'b0;
      prst_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      ic_q      <= ic_d;
      per_q     <= per_d;
      prst_q    <= ~per_d;
      done_q    <= per_d;
    end
  end

  assign interconnect_aresetn = ic_q;
  assign peripheral_aresetn   = per_q;
  assign peripheral_reset     = prst_q;
  assign seq_done             = done_q;
  assign seq_state            = state_q;
  assign restart_count        = restart_q;

endmodule
`default_nettype wire

// File: doc/platform_reset_sequencer.md
PLATFORM_RESET_SEQUENCER -- requirements
Module: platform_reset_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: cycles clk_wiz_locked_sync must stay high before any reset release.
REQ-002 SHALL have parameter STAGE_GAP, default 8: cycles between interconnect release and peripheral release.
REQ-003 SHALL have parameter SW_HOLD_CYCLES, default 16: cycles all resets are held after a software reset request.
REQ-004 SHALL have exactly one clock and an asynchronous, active-low reset, as follows.
REQ-005 pl_clk0  in  1  sole clock (CIPS PL clock 0).
REQ-006 pl_resetn  in  1  asynchronous active-low reset (CIPS pl_resetn).
REQ-007 clk_wiz_locked  in  1  clock-wizard locked, asynchronous to pl_clk0.
REQ-008 sw_reset_req  in  1  synchronous software reset request, level-sampled each cycle.
REQ-009 interconnect_aresetn  out  1  active-low reset to AXI interconnect/SmartConnect.
REQ-010 peripheral_aresetn  out  1  active-low reset to PL peripherals.
REQ-011 peripheral_reset  out  1  active-high copy, always equal to ~peripheral_aresetn.
REQ-012 seq_done  out  1  high only in RUN.
REQ-013 seq_state  out  3  current state encoding.
REQ-014 restart_count  out  8  saturating count of sequence restarts.

Function
REQ-015 clk_wiz_locked SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value, locked_s.
REQ-016 States and encodings SHALL be RESET=0, WAIT_LOCK=1, DEBOUNCE=2, REL_IC=3, RUN=4, SW_HOLD=5; codes 6-7 SHALL transition to RESET.
REQ-017 RESET SHALL go to WAIT_LOCK unconditionally on the next cycle.
REQ-018 WAIT_LOCK SHALL go to DEBOUNCE when locked_s=1; otherwise it SHALL remain in WAIT_LOCK.
REQ-019 On entry to DEBOUNCE the stage counter SHALL clear; DEBOUNCE SHALL last exactly DEBOUNCE_CYCLES cycles, then go to REL_IC; locked_s=0 in DEBOUNCE SHALL go to WAIT_LOCK with no count increment.
REQ-020 REL_IC SHALL last exactly STAGE_GAP cycles, then go to RUN.
REQ-021 RUN with locked_s=0 SHALL go to WAIT_LOCK and increment restart_count.
REQ-022 RUN with sw_reset_req=1 and locked_s=1 SHALL go to SW_HOLD and increment restart_count.
REQ-023 Loss of lock SHALL take priority over sw_reset_req in every state; a simultaneous event SHALL increment restart_count exactly once.
REQ-024 SW_HOLD SHALL last SW_HOLD_CYCLES cycles, then go to WAIT_LOCK; locked_s=0 SHALL go to WAIT_LOCK immediately; sw_reset_req in SW_HOLD SHALL be ignored.
REQ-025 In REL_IC, sw_reset_req SHALL be ignored; locked_s=0 SHALL go to WAIT_LOCK with no count increment.
REQ-026 interconnect_aresetn SHALL be 1 only in REL_IC and RUN.
REQ-027 peripheral_aresetn SHALL be 1 only in RUN.
REQ-028 All outputs SHALL be flops updated on the same edge as the state register, with zero cycles of decode lag.
REQ-029 restart_count SHALL saturate at 255 with no wrap.
REQ-030 The stage counter SHALL be sized as clog2 of max(DEBOUNCE_CYCLES, STAGE_GAP, SW_HOLD_CYCLES); each parameter SHALL be >=1.

Reset
REQ-031 pl_resetn=0 SHALL, asynchronously, force: state=RESET, both synchronizer flops=0, stage counter=0, restart_count=0, interconnect_aresetn=0, peripheral_aresetn=0, peripheral_reset=1, seq_done=0, seq_state=0.
REQ-032 Assertion of pl_resetn mid-sequence, including mid-RUN, SHALL abort the sequence immediately with no glitch-high on any active-low output.
REQ-033 Deassertion of pl_resetn SHALL be synchronized externally; the block SHALL NOT add a reset synchronizer.

Structure
REQ-034 The state encodings and default parameter constants SHALL reside in a shared package, platform_reset_pkg.
REQ-035 The 2-flop synchronizer SHALL be a sub-module, pl_sync_2ff, with async active-low reset, reusable elsewhere in the platform.

Verification
REQ-036 Bench SHALL cover: pl_resetn released with locked=1 from the start (edge 0) -> DEBOUNCE by edge 3, interconnect_aresetn=1 at edge 19, peripheral_aresetn=1 and seq_done=1 at edge 27.
REQ-037 Bench SHALL cover: locked drops for 5 cycles during DEBOUNCE -> return to WAIT_LOCK, restart_count=0, full DEBOUNCE of 16 cycles restarts after relock.
REQ-038 Bench SHALL cover: 1-cycle sw_reset_req in RUN -> both aresetn=0 next edge, restart_count=1, held 16 cycles, then full resequence back to RUN.
REQ-039 Bench SHALL cover: sw_reset_req and locked_s fall on the same cycle in RUN -> WAIT_LOCK (not SW_HOLD), restart_count increments by exactly 1.
REQ-040 Bench SHALL cover: 300 lock-loss restarts -> restart_count=255 and holding.
REQ-041 Bench SHALL cover: pl_resetn asserted mid-REL_IC -> all outputs at reset values in the same timestep, seq_state=0.
